// File: rtl/dmem_arbiter.sv
// Data RAM arbiter: the processor always wins the port, and a single buffered
// video read is issued in idle cycles. A bounded-wait monitor flags starvation.
module dmem_arbiter #(
    parameter int MAX_WAIT = 64,
    parameter int ADDR_W   = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ready,
    output logic              vid_rvalid,
    output logic [31:0]       vid_rdata,
    output logic              vid_starve,
    output logic [15:0]       vid_grants,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(MAX_WAIT);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic                inflight_q, inflight_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]         vid_rdata_q, vid_rdata_d;
    logic                vid_rvalid_q, vid_rvalid_d;
    logic                vid_starve_q, vid_starve_d;
    logic [15:0]         vid_grants_q, vid_grants_d;

    logic pend;
    logic accept;
    logic issue;
    logic blocked;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (vid_req) state_d = PENDING;
            PENDING: if (!cpu_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pend    = (state_q == PENDING);
        accept  = vid_req & ~pend;
        issue   = pend & ~cpu_req;
        blocked = pend & cpu_req;
    end

    // The CPU owns the port whenever it asks; video only fills idle cycles.
    always_comb begin
        ram_addr  = issue ? pend_addr_q : cpu_addr;
        ram_wen   = cpu_req & cpu_wen;
        ram_wdata = cpu_wdata;
        cpu_rdata = ram_rdata;
    end

    always_comb begin
        vid_ready  = ~pend;
        vid_rvalid = vid_rvalid_q;
        vid_rdata  = vid_rdata_q;
        vid_starve = vid_starve_q;
        vid_grants = vid_grants_q;
    end

    always_comb begin
        pend_addr_d  = pend_addr_q;
        wait_cnt_d   = wait_cnt_q;
        vid_rdata_d  = vid_rdata_q;
        vid_starve_d = vid_starve_q;
        vid_grants_d = vid_grants_q;
        inflight_d   = issue;
        vid_rvalid_d = inflight_q;
        if (accept) begin
            pend_addr_d = vid_addr;
            wait_cnt_d  = '0;
        end
        if (issue) begin
            vid_grants_d = vid_grants_q + 16'd1;
        end
        if (inflight_q) begin
            vid_rdata_d = ram_rdata;
        end
        if (blocked && wait_cnt_q != WAIT_LIM) begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
        if (blocked && wait_cnt_d == WAIT_LIM) begin
            vid_starve_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_addr_q  <= '0;
            inflight_q   <= 1'b0;
            wait_cnt_q   <= '0;
            vid_rdata_q  <= '0;
            vid_rvalid_q <= 1'b0;
            vid_starve_q <= 1'b0;
            vid_grants_q <= '0;
        end else begin
            pend_addr_q  <= pend_addr_d;
            inflight_q   <= inflight_d;
            wait_cnt_q   <= wait_cnt_d;
            vid_rdata_q  <= vid_rdata_d;
            vid_rvalid_q <= vid_rvalid_d;
            vid_starve_q <= vid_starve_d;
            vid_grants_q <= vid_grants_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model of the video path plus
// directed scenarios and a randomized run against a bench-side RAM.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int ADDR_W   = 12;

    logic              clock = 1'b0;
    logic              reset;
    logic              cpu_req;
    logic              cpu_wen;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ready;
    logic              vid_rvalid;
    logic [31:0]       vid_rdata;
    logic              vid_starve;
    logic [15:0]       vid_grants;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_wen    (cpu_wen),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ready  (vid_ready),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .vid_starve (vid_starve),
        .vid_grants (vid_grants),
        .ram_wen    (ram_wen),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clock = ~clock;

    logic [31:0] ram   [4096];
    logic [31:0] mem_m [4096];

    always @(posedge clock) begin
        if (ram_wen) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                age;
    } wreq_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;

    wreq_t             wq[$];
    ret_t              rq[$];
    int                cyc = 0;
    logic [31:0]       e_rdata = '0;
    logic [15:0]       e_grants = '0;
    logic              e_starve = 1'b0;
    logic [31:0]       e_cpu_rdata;
    logic              cpu_ok = 1'b0;
    logic              e_ready, e_issue, e_block, e_rvalid;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0]       rd;

    // Model: one waiting request, released in the first CPU-free cycle;
    // its data comes back two cycles after release.
    always @(negedge clock) begin
        #2;
        e_ready  = (wq.size() == 0);
        e_issue  = !e_ready && !cpu_req;
        e_block  = !e_ready && cpu_req;
        e_addr   = e_issue ? wq[0].addr : cpu_addr;
        e_rvalid = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e_rvalid = 1'b1;
            e_rdata  = rq[0].data;
            void'(rq.pop_front());
        end
        chk("vid_ready", {31'd0, vid_ready}, {31'd0, e_ready});
        chk("vid_rvalid", {31'd0, vid_rvalid}, {31'd0, e_rvalid});
        chk("vid_rdata", vid_rdata, e_rdata);
        chk("vid_grants", {16'd0, vid_grants}, {16'd0, e_grants});
        chk("vid_starve", {31'd0, vid_starve}, {31'd0, e_starve});
        chk("ram_addr", {20'd0, ram_addr}, {20'd0, e_addr});
        chk("ram_wen", {31'd0, ram_wen}, {31'd0, cpu_req & cpu_wen});
        chk("ram_wdata", ram_wdata, cpu_wdata);
        if (cpu_ok) chk("cpu_rdata", cpu_rdata, e_cpu_rdata);

        rd = mem_m[e_addr];
        if (cpu_req && cpu_wen) mem_m[cpu_addr] = cpu_wdata;
        e_cpu_rdata = rd;
        cpu_ok = 1'b1;
        if (reset) begin
            wq.delete();
            rq.delete();
            e_rdata  = '0;
            e_grants = '0;
            e_starve = 1'b0;
        end else begin
            if (e_issue) begin
                rq.push_back('{due: cyc + 2, data: rd});
                void'(wq.pop_front());
                e_grants++;
            end
            if (e_block) begin
                wq[0].age++;
                if (wq[0].age >= MAX_WAIT) e_starve = 1'b1;
            end
            if (vid_req && e_ready) wq.push_back('{addr: vid_addr, age: 0});
        end
        cyc++;
    end

    task automatic step(input logic rst, input logic cr, input logic cw,
                        input logic [ADDR_W-1:0] ca, input logic [31:0] cd,
                        input logic vr, input logic [ADDR_W-1:0] va);
        @(negedge clock);
        reset     = rst;
        cpu_req   = cr;
        cpu_wen   = cw;
        cpu_addr  = ca;
        cpu_wdata = cd;
        vid_req   = vr;
        vid_addr  = va;
        #3;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]   = i * 32'h9E37_79B9;
            mem_m[i] = i * 32'h9E37_79B9;
        end
        reset = 1'b1; cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0;
        cpu_wdata = '0; vid_req = 1'b1; vid_addr = 12'h005;

        // reset held with a request present
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 12'h005);
        idle();
        chk("rst_ready", {31'd0, vid_ready}, 32'd1);
        chk("rst_rvalid", {31'd0, vid_rvalid}, 32'd0);
        chk("rst_grants", {16'd0, vid_grants}, 32'd0);
        chk("rst_starve", {31'd0, vid_starve}, 32'd0);

        // idle read
        step(1'b0, 1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 12'h010);
        chk("idle_accept", {31'd0, vid_ready}, 32'd1);
        idle();
        chk("idle_issue_addr", {20'd0, ram_addr}, 32'h010);
        chk("idle_issue_wen", {31'd0, ram_wen}, 32'd0);
        chk("idle_busy", {31'd0, vid_ready}, 32'd0);
        idle();
        chk("idle_t2_rvalid", {31'd0, vid_rvalid}, 32'd0);
        idle();
        chk("idle_rvalid", {31'd0, vid_rvalid}, 32'd1);
        chk("idle_rdata", vid_rdata, 32'hDEAD_BEEF);
        chk("idle_grants", {16'd0, vid_grants}, 32'd1);

        // CPU priority with starvation after the 4th blocked cycle
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 12'h011);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b1, 1'b0, 12'h0AA, '0, 1'b0, '0);
            chk("prio_addr", {20'd0, ram_addr}, 32'h0AA);
            chk("prio_ready", {31'd0, vid_ready}, 32'd0);
            if (k == 4) chk("starve_pre", {31'd0, vid_starve}, 32'd0);
            if (k == 5) chk("starve_set", {31'd0, vid_starve}, 32'd1);
        end
        idle();
        chk("prio_issue_addr", {20'd0, ram_addr}, 32'h011);
        chk("prio_issue_ready", {31'd0, vid_ready}, 32'd0);
        idle();
        chk("prio_ready_back", {31'd0, vid_ready}, 32'd1);
        idle();
        chk("prio_rvalid", {31'd0, vid_rvalid}, 32'd1);
        chk("prio_grants", {16'd0, vid_grants}, 32'd2);
        chk("starve_sticky", {31'd0, vid_starve}, 32'd1);

        // store and pending read to the same word
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 12'h020);
        step(1'b0, 1'b1, 1'b1, 12'h020, 32'h1234_5678, 1'b0, '0);
        idle();
        chk("coh_issue_addr", {20'd0, ram_addr}, 32'h020);
        idle();
        idle();
        chk("coh_rvalid", {31'd0, vid_rvalid}, 32'd1);
        chk("coh_rdata", vid_rdata, 32'h1234_5678);
        chk("coh_starve", {31'd0, vid_starve}, 32'd1);

        // reset in the issue cycle
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 12'h030);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        chk("mid_issue_addr", {20'd0, ram_addr}, 32'h030);
        idle();
        chk("mid_ready", {31'd0, vid_ready}, 32'd1);
        chk("mid_grants", {16'd0, vid_grants}, 32'd0);
        chk("mid_starve", {31'd0, vid_starve}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("mid_no_rvalid", {31'd0, vid_rvalid}, 32'd0);
            idle();
        end

        // back-to-back requests: one read per two cycles
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 12'(12'h040 + k));
        end
        idle();
        chk("tput_grants", {16'd0, vid_grants}, 32'd5);
        idle();
        idle();

        // randomized traffic on a small address window
        for (int k = 0; k < 4000; k++) begin
            step(($urandom_range(255) == 0),
                 ($urandom_range(99) < 45),
                 ($urandom_range(1) == 1),
                 12'($urandom_range(15)),
                 $urandom,
                 ($urandom_range(99) < 60),
                 12'($urandom_range(15)));
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
